// File: rtl/seven_seg_pkg.sv
// Segment patterns shared by the seven_seg encoder and reader, plus the reader FSM encoding.
// Bit order everywhere is {a,b,c,d,e,f,g}.
package seven_seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_VALID = 1'b1
   } state_t;

   typedef struct packed {
      logic       hit;
      logic [2:0] digit;
   } seg_dec_t;

   function automatic seg_dec_t seg_decode(input logic [6:0] pat);
      seg_dec_t d;
      d.hit   = 1'b1;
      d.digit = 3'd0;
      case (pat)
         SEG_0:   d.digit = 3'd0;
         SEG_1:   d.digit = 3'd1;
         SEG_2:   d.digit = 3'd2;
         SEG_3:   d.digit = 3'd3;
         SEG_4:   d.digit = 3'd4;
         SEG_5:   d.digit = 3'd5;
         SEG_6:   d.digit = 3'd6;
         SEG_7:   d.digit = 3'd7;
         default: d.hit   = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/seg_stab_filter.sv
// Registers the segment bus and counts consecutive identical samples, saturating at STABLE_CYCLES.
// stable means the registered pattern has been seen unchanged for STABLE_CYCLES further edges.
module seg_stab_filter #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_in,
   output logic [6:0] seg_q,
   output logic       stable
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= '0;
         cnt   <= '0;
      end else begin
         if (seg_in == seg_q) begin
            if (cnt != CNT_MAX)
               cnt <= cnt + CNT_W'(1);
         end else begin
            cnt <= '0;
         end
         seg_q <= seg_in;
      end
   end

   assign stable = (cnt == CNT_MAX);

endmodule

// File: rtl/seven_seg_reader.sv
// Recovers a 3-bit digit from seven segment lines with stability filtering, illegal-pattern
// flagging, duplicate suppression and a valid/ready result handshake.
//
// state   | meaning
// S_IDLE  | waiting for a stable pattern that differs from the last one accepted
// S_VALID | result presented on out_digit/out_err until out_ready
module seven_seg_reader
   import seven_seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       seg_a,
   input  logic       seg_b,
   input  logic       seg_c,
   input  logic       seg_d,
   input  logic       seg_e,
   input  logic       seg_f,
   input  logic       seg_g,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [2:0] out_digit,
   output logic       out_err
);

   logic [6:0] seg_in;
   logic [6:0] seg_q;
   logic       stable;
   logic [6:0] last_pat;
   state_t     state;
   seg_dec_t   dec;

   assign seg_in = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

   seg_stab_filter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .seg_in (seg_in),
      .seg_q  (seg_q),
      .stable (stable)
   );

   assign dec = seg_decode(seg_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         last_pat  <= SEG_BLANK;
         out_valid <= 1'b0;
         out_digit <= 3'd0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (stable && (seg_q != last_pat)) begin
                  // A stable blank only re-arms, so the next identical digit is reported again.
                  if (seg_q == SEG_BLANK) begin
                     last_pat <= SEG_BLANK;
                  end else begin
                     last_pat  <= seg_q;
                     out_digit <= dec.hit ? dec.digit : 3'd0;
                     out_err   <= ~dec.hit;
                     out_valid <= 1'b1;
                     state     <= S_VALID;
                  end
               end
            end
            S_VALID: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: table-driven vectors feeding a result scoreboard,
// plus hand-written latency, stall and asynchronous-reset sequences.
module tb_seven_seg_reader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] seg = 7'b0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [2:0] out_digit;
   logic       out_err;

   int checks = 0;
   int errors = 0;

   logic [3:0] sb[$];   // {err, digit}

   always #5 clk = ~clk;

   seven_seg_reader #(.STABLE_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seg_a     (seg[6]),
      .seg_b     (seg[5]),
      .seg_c     (seg[4]),
      .seg_d     (seg[3]),
      .seg_e     (seg[2]),
      .seg_f     (seg[1]),
      .seg_g     (seg[0]),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_digit (out_digit),
      .out_err   (out_err)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard: every completed transfer must match the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got digit %0d err %0d, expected none", out_digit, out_err);
         end else begin
            logic [3:0] e;
            e = sb.pop_front();
            check("result_digit", int'(out_digit), int'(e[2:0]));
            check("result_err", int'(out_err), int'(e[3]));
         end
      end
   end

   task automatic do_reset();
      seg = 7'b0;
      out_ready = 1'b0;
      rst_n = 1'b0;
      sb.delete();
      #2;
      check("reset_valid", int'(out_valid), 0);
      check("reset_digit", int'(out_digit), 0);
      check("reset_err", int'(out_err), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit         rst;
      logic [6:0] pat;
      int         cycles;
      bit         rep;
      logic [2:0] dig;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // sweep 0..7
      vecs.push_back('{1, 7'b1111110, 8, 1, 3'd0, 1'b0});
      vecs.push_back('{0, 7'b0110000, 8, 1, 3'd1, 1'b0});
      vecs.push_back('{0, 7'b1101101, 8, 1, 3'd2, 1'b0});
      vecs.push_back('{0, 7'b1111001, 8, 1, 3'd3, 1'b0});
      vecs.push_back('{0, 7'b0110011, 8, 1, 3'd4, 1'b0});
      vecs.push_back('{0, 7'b1011011, 8, 1, 3'd5, 1'b0});
      vecs.push_back('{0, 7'b1011111, 8, 1, 3'd6, 1'b0});
      vecs.push_back('{0, 7'b1110000, 8, 1, 3'd7, 1'b0});
      // illegal pattern
      vecs.push_back('{0, 7'b1010101, 8, 1, 3'd0, 1'b1});
      // glitch rejected
      vecs.push_back('{1, 7'b1111110, 3, 0, 3'd0, 1'b0});
      vecs.push_back('{0, 7'b0110011, 8, 1, 3'd4, 1'b0});
      // repeat with blank in between
      vecs.push_back('{1, 7'b1101101, 8, 1, 3'd2, 1'b0});
      vecs.push_back('{0, 7'b0000000, 5, 0, 3'd0, 1'b0});
      vecs.push_back('{0, 7'b1101101, 8, 1, 3'd2, 1'b0});
      // repeat without blank
      vecs.push_back('{1, 7'b1101101, 8, 1, 3'd2, 1'b0});
      vecs.push_back('{0, 7'b1101101, 8, 0, 3'd0, 1'b0});

      // Latency: single pulse visible after the 5th edge, none afterwards.
      do_reset();
      seg = 7'b0110000;
      out_ready = 1'b1;
      sb.push_back({1'b0, 3'd1});
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("latency_valid_e%0d", i), int'(out_valid), (i == 5) ? 1 : 0);
      end
      @(posedge clk);
      #1;
      check("latency_sb_empty", sb.size(), 0);

      for (int v = 0; v < vecs.size(); v++) begin
         if (vecs[v].rst) begin
            hold(3);
            check($sformatf("vec%0d_sb_empty", v), sb.size(), 0);
            do_reset();
         end
         seg = vecs[v].pat;
         out_ready = 1'b1;
         if (vecs[v].rep)
            sb.push_back({vecs[v].err, vecs[v].dig});
         hold(vecs[v].cycles);
      end
      hold(10);
      check("table_sb_empty", sb.size(), 0);

      // Stall: 5 held through the stall, then 7 reported after the handshake.
      do_reset();
      seg = 7'b1011011;
      out_ready = 1'b0;
      sb.push_back({1'b0, 3'd5});
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (i == 12) begin
            seg = 7'b1110000;
            sb.push_back({1'b0, 3'd7});
         end
         @(negedge clk);
         if (i >= 5) begin
            check($sformatf("stall_valid_%0d", i), int'(out_valid), 1);
            check($sformatf("stall_digit_%0d", i), int'(out_digit), 5);
         end
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      hold(8);
      check("stall_sb_empty", sb.size(), 0);

      // Asynchronous reset mid-handshake.
      do_reset();
      seg = 7'b1111001;
      out_ready = 1'b0;
      sb.push_back({1'b0, 3'd3});
      begin
         int n;
         n = 0;
         while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("async_wait_valid", int'(out_valid), 1);
         check("async_pre_digit", int'(out_digit), 3);
      end
      #2;
      sb.delete();
      rst_n = 1'b0;
      #1;
      check("async_valid", int'(out_valid), 0);
      check("async_digit", int'(out_digit), 0);
      check("async_err", int'(out_err), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      hold(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
- Inverse of the team's seven_seg digit-to-segment encoder: samples the seven segment lines seg_a..seg_g and recovers the 3-bit digit.
- Adds stability filtering, illegal-pattern detection and a valid/ready output handshake.
- Sits between a segment bus (driven by an encoder or an external display tap) and downstream logic; the loopback checker for seven_seg in the multiplier display path.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted; legal range 1..15.
- CNT_W, localparam = $clog2(STABLE_CYCLES+1), stability counter width; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_a..seg_g  input  1 each  segment lines, active-high; packed internally as {a,b,c,d,e,f,g}.
- out_ready  input  1  consumer accepts the result when high with out_valid.
- out_valid  output  1  result available.
- out_digit  output  3  decoded digit 0..7.
- out_err  output  1  accepted pattern is non-blank and not in the table.

Behaviour:
- Decode table, {a..g}:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - blank=0000000
- Reset (async, rst_n low): seg_q=0, cnt=0, last_pat=0, state=S_IDLE, out_valid=0, out_digit=0, out_err=0.
- Sampling, every edge:
  - If input == seg_q, cnt increments and saturates at STABLE_CYCLES; otherwise cnt resets to 0.
  - seg_q is then loaded with the input.
- FSM, 2 states:
  - S_IDLE, accept condition: cnt == STABLE_CYCLES and seg_q != last_pat.
    - seg_q blank: last_pat becomes 0 (re-arm); no output; stay in S_IDLE.
    - seg_q in table: out_digit = table index, out_err = 0, last_pat = seg_q, go to S_VALID.
    - seg_q not in table: out_digit = 0, out_err = 1, last_pat = seg_q, go to S_VALID.
  - S_VALID:
    - out_valid = 1; out_digit and out_err held constant.
    - On out_ready = 1: out_valid drops at that edge, return to S_IDLE.
    - Segment changes are still sampled and counted but cannot load new output.
- Latency: pattern first sampled at edge E0 with input held constant, out_valid visible after edge E(STABLE_CYCLES+1); with default 4, after the 5th edge.
- Duplicate suppression: a pattern equal to last_pat is not re-reported until a different pattern (blank included) is accepted.
- Boundary cases:
  - Glitch shorter than STABLE_CYCLES+1 samples: cnt resets, nothing reported.
  - New pattern becomes stable while in S_VALID: reported after out_ready returns FSM to S_IDLE, provided it is still stable and != last_pat. No queueing beyond that.
  - out_ready high in S_IDLE: ignored.
  - rst_n asserted mid-handshake: out_valid drops immediately (async); result is lost.
  - rst_n deassertion: first accept no earlier than STABLE_CYCLES+1 edges later.

Decomposition:
- Shared package / include (seven_seg_pkg):
  - the 8 segment-pattern constants (SEG_0..SEG_7) and SEG_BLANK, shared with seven_seg so the two cannot diverge;
  - state encodings S_IDLE = 1'b0, S_VALID = 1'b1.
- One natural sub-module: seg_stab_filter (seg_q register plus saturating counter, exposing stable and seg_q).
- Table lookup and FSM stay in the top module.

Test Plan:
- Reset, then hold 0110000 for 10 cycles with out_ready = 1 -> single out_valid pulse after edge 5, out_digit = 1, out_err = 0; no second pulse.
- Sweep digits 0..7, each driven 8 cycles (pattern from the table), out_ready = 1 -> eight results in order 0..7, all out_err = 0.
- Drive 1011011 (5), hold out_ready = 0 for 20 cycles, change input to 1110000 (7) at cycle 12, then raise out_ready:
  - out_digit stays 5 throughout the stall;
  - after the handshake, digit 7 is reported.
- Drive 1111110 for 3 cycles, then 0110011 stable -> only digit 4 reported (glitch rejected).
- Drive 1010101 stable -> out_valid with out_err = 1, out_digit = 0.
- Repeat test: 1101101 stable, blank for 5 cycles, 1101101 again -> digit 2 reported twice. The same sequence without the blank -> reported once.
- Assert rst_n low while out_valid = 1 -> out_valid = 0 with no clock edge; outputs at reset values.
